// File: rtl/fifo_pkg.sv
// Shared types and defaults for the parametrised synchronous FIFO family.
// The typedefs describe the default 16-entry geometry; modules size their own vectors with cnt_w().
package fifo_pkg;

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_PTR_W    = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W    = DEF_PTR_W + 1;
  localparam int DEF_AF_LEVEL = DEF_DEPTH - 2;
  localparam int DEF_AE_LEVEL = 2;

  typedef logic [DEF_PTR_W-1:0] ptr_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } rd_mode_e;

  // Count needs one extra bit over the pointer so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port addressed by the read pointer.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered level flags, occupancy count, sticky error flags
// and a selectable standard or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = fifo_pkg::DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = fifo_pkg::DEF_AE_LEVEL,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  import fifo_pkg::*;

  localparam int       PW   = $clog2(DEPTH);
  localparam int       CW   = cnt_w(DEPTH);
  localparam rd_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d, mem_rdata;
  logic             empty_q, full_q, ae_q, af_q, ovf_q, udf_q;
  logic             wr_ok, rd_ok;

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (din),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_rdata)
  );

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  always_comb begin
    rd_ok    = rd & ~empty_q;
    wr_ok    = wr & (~full_q | rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    // In FWFT mode the register tracks the visible head so it can be held once empty.
    if (MODE == fifo_pkg::STD) begin
      if (rd_ok) dout_d = mem_rdata;
    end else begin
      if (!empty_q) dout_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CW'(DEPTH));
      ae_q     <= (count_d <= CW'(AE_LEVEL));
      af_q     <= (count_d >= CW'(AF_LEVEL));
      ovf_q    <= ovf_q | (wr & ~wr_ok);
      udf_q    <= udf_q | (rd & ~rd_ok);
    end
  end

  assign dout         = (MODE == fifo_pkg::FWFT && !empty_q) ? mem_rdata : dout_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int SW    = CW + 6;

  logic clk, rst, wr, rd;
  logic [7:0] din;
  logic [7:0] s_dout, f_dout;
  logic s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [CW-1:0] s_count, f_count;
  logic [SW-1:0] s_stat, f_stat;

  int total = 0;
  int bad   = 0;

  // ---------------- clock/reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(s_dout),
    .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(f_dout),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  assign s_stat = {s_empty, s_full, s_ae, s_af, s_count, s_ovf, s_udf};
  assign f_stat = {f_empty, f_full, f_ae, f_af, f_count, f_ovf, f_udf};

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_dout, m_fdout;

  task automatic model_step();
    int  n;
    bit  rok, wok;
    if (!rst) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_dout = '0; m_fdout = '0;
      return;
    end
    n   = mq.size();
    rok = rd && (n > 0);
    wok = wr && ((n < DEPTH) || rok);
    if (rok) m_dout = mq.pop_front();
    if (wok) mq.push_back(din);
    if (wr && !wok) m_ovf = 1;
    if (rd && !rok) m_udf = 1;
    if (mq.size() > 0) m_fdout = mq[0];
  endtask

  function automatic logic [SW-1:0] exp_stat();
    int n;
    n = mq.size();
    return {n == 0, n == DEPTH, n <= 2, n >= 14, CW'(n), m_ovf, m_udf};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; din = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(0, 0, 8'h00);
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({s_stat, f_stat, s_dout, f_dout} !== {11'b1010_00000_00, 11'b1010_00000_00, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset: got std=%b fwft=%b dout=%h/%h exp 10100000000 and dout 00", s_stat, f_stat, s_dout, f_dout);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      tick(1, 0, 8'(i));
      total++;
      if ({s_stat, f_stat, s_dout, f_dout} !== {exp_stat(), exp_stat(), m_dout, m_fdout}) begin
        bad++;
        $display("FAIL fill[%0d]: got %b %b %h %h exp %b %h %h", i, s_stat, f_stat, s_dout, f_dout, exp_stat(), m_dout, m_fdout);
      end
    end
    total++;
    if ({s_full, s_count, s_ovf} !== {1'b1, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL fill_end: got full=%b count=%0d ovf=%b exp 1 16 0", s_full, s_count, s_ovf);
    end
  endtask

  task automatic test_overflow_drain();
    tick(1, 0, 8'hAA);
    total++;
    if ({s_stat, f_stat} !== {exp_stat(), exp_stat()} || s_ovf !== 1'b1) begin
      bad++;
      $display("FAIL overflow: got %b %b exp %b", s_stat, f_stat, exp_stat());
    end
    for (int i = 1; i <= 16; i++) begin
      tick(0, 1, 8'h00);
      total++;
      if ({s_stat, f_stat, s_dout, f_dout} !== {exp_stat(), exp_stat(), m_dout, m_fdout} || s_dout !== 8'(i)) begin
        bad++;
        $display("FAIL drain[%0d]: got %b %b %h %h exp %b %h %h", i, s_stat, f_stat, s_dout, f_dout, exp_stat(), m_dout, m_fdout);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] prev;
    prev = s_dout;
    tick(0, 1, 8'h00);
    total++;
    if ({s_stat, f_stat} !== {exp_stat(), exp_stat()} || s_udf !== 1'b1 || s_dout !== prev) begin
      bad++;
      $display("FAIL underflow: got %b dout=%h exp %b dout=%h", s_stat, s_dout, exp_stat(), prev);
    end
    tick(1, 1, 8'h55);
    total++;
    if ({s_stat, f_stat, s_dout, f_dout} !== {exp_stat(), exp_stat(), m_dout, m_fdout} || s_count !== 5'd1) begin
      bad++;
      $display("FAIL empty_wr_rd: got %b %b %h %h exp %b %h %h", s_stat, f_stat, s_dout, f_dout, exp_stat(), m_dout, m_fdout);
    end
  endtask

  task automatic test_full_wr_rd();
    do_reset();
    for (int i = 1; i <= 16; i++) tick(1, 0, 8'(i));
    tick(1, 1, 8'h77);
    total++;
    if ({s_stat, f_stat, s_dout, f_dout} !== {exp_stat(), exp_stat(), m_dout, m_fdout} || s_dout !== 8'h01) begin
      bad++;
      $display("FAIL full_wr_rd: got %b %b %h %h exp %b 01 %h", s_stat, f_stat, s_dout, f_dout, exp_stat(), m_fdout);
    end
    for (int i = 0; i < 16; i++) begin
      tick(0, 1, 8'h00);
      total++;
      if ({s_stat, f_stat, s_dout, f_dout} !== {exp_stat(), exp_stat(), m_dout, m_fdout}) begin
        bad++;
        $display("FAIL full_drain[%0d]: got %b %b %h %h exp %b %h %h", i, s_stat, f_stat, s_dout, f_dout, exp_stat(), m_dout, m_fdout);
      end
    end
    total++;
    if (s_dout !== 8'h77) begin
      bad++;
      $display("FAIL full_last: got %h exp 77", s_dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] nxt;
    do_reset();
    exp_q.delete();
    nxt = 8'h10;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(nxt);
      tick(1, 0, nxt);
      nxt++;
    end
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(nxt);
      tick(1, 1, nxt);
      nxt++;
      total++;
      if ({s_stat, f_stat, f_dout} !== {exp_stat(), exp_stat(), m_fdout} || s_dout !== exp_q.pop_front()) begin
        bad++;
        $display("FAIL wrap[%0d]: got %b %b %h %h exp %b %h", i, s_stat, f_stat, s_dout, f_dout, exp_stat(), m_dout);
      end
    end
  endtask

  task automatic test_random();
    logic w, r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Alternate fill-leaning and drain-leaning phases to reach both ends often.
      w = ($urandom_range(0, 99) < (((i / 50) % 2 == 0) ? 75 : 30));
      r = ($urandom_range(0, 99) < (((i / 50) % 2 == 0) ? 30 : 75));
      rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      tick(w, r, 8'($urandom_range(0, 255)));
      rst = 1'b1;
      total++;
      if ({s_stat, f_stat, s_dout, f_dout} !== {exp_stat(), exp_stat(), m_dout, m_fdout}) begin
        bad++;
        $display("FAIL random[%0d]: got %b %b %h %h exp %b %h %h", i, s_stat, f_stat, s_dout, f_dout, exp_stat(), m_dout, m_fdout);
      end
    end
  endtask

  task automatic test_fwft_reset();
    do_reset();
    tick(1, 0, 8'h3C);
    total++;
    if (f_dout !== 8'h3C || f_empty !== 1'b0) begin
      bad++;
      $display("FAIL fwft_head: got dout=%h empty=%b exp 3c 0", f_dout, f_empty);
    end
    for (int i = 0; i < 4; i++) tick(1, 0, 8'(8'hC0 + i));
    total++;
    if ({f_stat, f_dout} !== {exp_stat(), m_fdout} || f_count !== 5'd5) begin
      bad++;
      $display("FAIL fwft_five: got %b %h exp %b %h", f_stat, f_dout, exp_stat(), m_fdout);
    end
    rst = 1'b0;
    tick(1, 1, 8'hEE);
    rst = 1'b1;
    total++;
    if ({s_stat, f_stat} !== {11'b1010_00000_00, 11'b1010_00000_00}) begin
      bad++;
      $display("FAIL midreset: got %b %b exp 10100000000", s_stat, f_stat);
    end
    tick(0, 0, 8'h00);
    total++;
    if ({s_stat, f_stat, s_dout, f_dout} !== {exp_stat(), exp_stat(), m_dout, m_fdout}) begin
      bad++;
      $display("FAIL post_reset: got %b %b %h %h exp %b %h %h", s_stat, f_stat, s_dout, f_dout, exp_stat(), m_dout, m_fdout);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_full_wr_rd();
    test_back_to_back();
    test_fwft_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
